// File: rtl/bit4_serial_sub_if.sv
// Request/result bundle for the bit-serial subtractor.
// The master side issues start with operands; the slave side reports progress and the result.
interface bit4_serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Ovf;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Borrow, Ovf
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Borrow, Ovf
  );
endinterface

// File: rtl/bit4_serial_sub.sv
// Bit-serial subtractor: computes A - B one bit per clock, LSB first, using a
// single full-subtractor cell and a borrow flop. A request is accepted only
// while idle. The result appears WIDTH edges later with a one-cycle done pulse.
// WIDTH must match the WIDTH of the connected interface instance.
module bit4_serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  bit4_serial_sub_if.slave bus
);

  localparam int CNT_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only the upper WIDTH-1 result bits need storing. The newest bit joins them on completion.
  logic [WIDTH-2:0] r_sr;
  logic             bflop;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             bo;
  logic [WIDTH-1:0] r_next;

  // Full-subtractor cell on the current LSBs plus the incoming borrow.
  assign d      = a_sr[0] ^ b_sr[0] ^ bflop;
  assign bo     = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bflop);
  assign r_next = {d, r_sr};

  assign bus.busy = (state == SHIFT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept from idle, finish after the last bit.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned, which would infer a latch.
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one bit per shift cycle, result publish on finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      bflop      <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      bus.done   <= 1'b0;
      bus.Diff   <= '0;
      bus.Borrow <= 1'b0;
      bus.Ovf    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        a_sr  <= bus.A;
        b_sr  <= bus.B;
        bflop <= 1'b0;
        cnt   <= '0;
        a_msb <= bus.A[WIDTH-1];
        b_msb <= bus.B[WIDTH-1];
      end
      if (state == SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        r_sr  <= r_next[WIDTH-1:1];
        bflop <= bo;
        cnt   <= cnt + 1'b1;
      end
      if (finish) begin
        bus.done   <= 1'b1;
        bus.Diff   <= r_next;
        bus.Borrow <= bo;
        // Signed overflow occurs only when the operand signs differ and the result sign differs from A.
        bus.Ovf    <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end

endmodule
